mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// Initiator side of the data-memory interface: sits in the MEM stage between the pipeline and the
// word-organised data memory. Converts sb/sh/sw/lb/lbu/lh/lhu/lw into word-aligned bus transactions
// with byte enables. Replicates store data across lanes and extracts and extends load data.
// Stalls the pipeline until the memory acknowledges, and flags misaligned and timed-out accesses.
// PARAMETERS
// TIMEOUT_CYC  16  cycles in BUSY without mem_ack before the access aborts (>=2)
// CNT_W        5   width of the timeout counter (must hold TIMEOUT_CYC)
// PORTS
// clk          in   1   clock, all state updates on posedge
// reset        in   1   synchronous, active-high
// req_valid    in   1   MEM stage holds a load/store; request fields are stable while stall=1
// req_write    in   1   1=store, 0=load
// req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
// req_unsigned in   1   loads only: 1=zero-extend (lbu/lhu), 0=sign-extend
// req_addr     in   32  byte address
// req_wdata    in   32  store data, low bits significant
// stall        out  1   freeze pipeline (combinational from state/req)
// done         out  1   one-cycle pulse: access finished, rdata/exc valid
// rdata        out  32  extended load data (0 for stores and exceptions)
// exc          out  1   exception with done
// exc_code     out  2   01 misaligned/illegal size, 10 timeout, 00 none
// mem_req      out  1   bus request, held until mem_ack sampled
// mem_we       out  1   bus write
// mem_addr     out  32  {req_addr[31:2],2'b00}
// mem_be       out  4   byte enables, bit i = byte lane i (bits 8i+7:8i)
// mem_wdata    out  32  lane-replicated store data
// mem_ack      in   1   memory completes the current request this cycle
// mem_rdata    in   32  full word, valid with mem_ack
// BEHAVIOUR
// - FSM states: IDLE, BUSY, RESP. Reset -> IDLE; all registered outputs 0, counter 0.
// - IDLE, req_valid=0: stay in IDLE, stall=0.
// - IDLE, req_valid=1, aligned: latch the request. Next state BUSY with mem_req=1 and bus fields
//   registered. stall=1.
// - Misaligned means: half with addr[0]=1; word with addr[1:0]!=0; size=11.
// - IDLE, req_valid=1, misaligned: no bus request. Next state RESP with exc=1, exc_code=01,
//   rdata=0. stall=1.
// - BUSY: stall=1; mem_req, mem_we, mem_addr, mem_be and mem_wdata held constant.
//   - mem_ack=1 at the edge: mem_req drops to 0. rdata is captured (load) or set to 0 (store).
//     Next state RESP.
//   - otherwise the counter increments. When it reaches TIMEOUT_CYC-1 with no ack: mem_req drops,
//     exc_code=10, rdata=0, next state RESP.
//   - An ack in the same cycle as the timeout wins: normal completion.
// - RESP: done=1, stall=0, so the pipeline advances on this edge. Next state is always IDLE.
//   The held request is not re-accepted. Counter cleared; exc and done return to 0 afterwards.
// - Latency: an access with ack in its first BUSY cycle completes at IDLE->BUSY->RESP, so stall
//   is high for 2 cycles. Each extra wait cycle adds 1.
// - Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
//   Loads drive the same mem_be.
// - Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
// - Load data: byte lane = mem_rdata[8*addr[1:0]+7 -: 8]; half = mem_rdata[16*addr[1]+15 -: 16].
//   Extended to 32 bits per req_unsigned. Word is passed through unchanged.
// - mem_ack while in IDLE or RESP (a late or stray ack) is ignored.
// - Reset mid-access: at the reset edge -> IDLE, mem_req=0, done=0, exc=0. No completion is
//   reported for the aborted access.
// TESTING
// 1. sb addr=0x1003 wdata=0x000000AB, ack on 2nd BUSY cycle -> mem_addr=0x1000, be=1000,
//    mem_wdata=0xABABABAB, we=1, stall high 3 cycles, done=1 rdata=0.
// 2. lb addr=0x2002, mem_rdata=0x12F45678, ack immediate -> rdata=0xFFFFFFF4.
//    The same access as lbu -> 0x000000F4. be=0100 in both cases.
// 3. lh addr=0x2002, mem_rdata=0x80010000 -> rdata=0xFFFF8001, be=1100.
//    lhu -> 0x00008001. lw 0x2000 -> 0x80010000.
// 4. lw addr=0x0006 -> mem_req never asserted; next cycle done=1, exc=1, exc_code=01.
//    size=11 at 0x0 gives the same result.
// 5. TIMEOUT_CYC=4, sw with mem_ack held 0 -> mem_req high exactly 4 cycles, then done=1,
//    exc_code=10. A later ack is ignored.
// 6. reset=1 on the 2nd BUSY cycle of an lw -> next cycle mem_req=0, stall=0, done=0.
//    An ack the following cycle causes no done; a new sw then proceeds normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-organised data memory.
// Turns byte/half/word loads and stores into aligned bus transfers with byte enables, and stalls until acked or timed out.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [1:0]  exc_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_lo;
    logic [1:0]       lat_size;
    logic             lat_uns;

    logic             misaligned_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [7:0]       lane_b_c;
    logic [15:0]      lane_h_c;
    logic [31:0]      load_c;
    logic             timeout_c;

    assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Request decode: alignment check, lane enables, replicated store data
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        wdata_c      = 32'h0;
        case (req_size)
            2'b00: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_c         = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{req_wdata[15:0]}};
                misaligned_c = req_addr[0];
            end
            2'b10: begin
                be_c         = 4'b1111;
                wdata_c      = req_wdata;
                misaligned_c = |req_addr[1:0];
            end
            default: misaligned_c = 1'b1;
        endcase
    end

    // Lane extraction and extension of the returned word
    always_comb begin
        lane_b_c = 8'(mem_rdata >> {lat_lo, 3'b000});
        lane_h_c = 16'(mem_rdata >> {lat_lo[1], 4'b0000});
        case (lat_size)
            2'b00:   load_c = lat_uns ? {24'h0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
            2'b01:   load_c = lat_uns ? {16'h0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
            default: load_c = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = misaligned_c ? RESP : BUSY;
            BUSY: if (mem_ack || timeout_c) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = req_valid;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Bus fields, counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_lo    <= 2'b00;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            done      <= 1'b0;
            rdata     <= 32'h0;
            exc       <= 1'b0;
            exc_code  <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    exc      <= 1'b0;
                    exc_code <= 2'b00;
                    cnt      <= '0;
                    if (req_valid) begin
                        if (misaligned_c) begin
                            done     <= 1'b1;
                            exc      <= 1'b1;
                            exc_code <= 2'b01;
                            rdata    <= 32'h0;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                            lat_lo    <= req_addr[1:0];
                            lat_size  <= req_size;
                            lat_uns   <= req_unsigned;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        done     <= 1'b1;
                        rdata    <= mem_we ? 32'h0 : load_c;
                        exc      <= 1'b0;
                        exc_code <= 2'b00;
                    end else if (timeout_c) begin
                        mem_req  <= 1'b0;
                        done     <= 1'b1;
                        rdata    <= 32'h0;
                        exc      <= 1'b1;
                        exc_code <= 2'b10;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    done     <= 1'b0;
                    exc      <= 1'b0;
                    exc_code <= 2'b00;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues accesses and acts as the memory,
// a monitor compares bus fields and completions against queued expectations.
module tb_mem_access_unit;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        exc;
    logic [1:0]  exc_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    mem_access_unit #(.TIMEOUT_CYC(T), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .rdata(rdata), .exc(exc), .exc_code(exc_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          bus;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exc;
        logic [1:0]  code;
        int          stall_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: expected bus transfer and completion for one access
    function automatic exp_t model(input bit w, input logic [1:0] sz, input bit uns,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input int d, input logic [31:0] rw);
        exp_t e;
        int unsigned ofs;
        int unsigned v;
        ofs = int'(a % 4);
        e.we = w;
        e.addr = a - ofs;
        e.bus = 1'b1;
        e.exc = 1'b0;
        e.code = 2'b00;
        e.rdata = 32'h0;
        if (sz == 2'd3 || (sz == 2'd1 && ofs % 2 != 0) || (sz == 2'd2 && ofs != 0)) begin
            e.bus = 1'b0; e.exc = 1'b1; e.code = 2'b01;
            e.be = 4'h0; e.wdata = 32'h0; e.stall_cyc = 1;
            return e;
        end
        if (sz == 2'd0) begin
            e.be = 4'(1 << ofs);
            e.wdata = (wd & 32'hFF) * 32'h01010101;
            v = (rw >> (8 * ofs)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            e.be = (ofs >= 2) ? 4'hC : 4'h3;
            e.wdata = (wd & 32'hFFFF) * 32'h00010001;
            v = (rw >> (8 * ofs)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            e.be = 4'hF;
            e.wdata = wd;
            v = rw;
        end
        if (d < int'(T)) begin
            e.rdata = w ? 32'h0 : v;
            e.stall_cyc = d + 2;
        end else begin
            e.exc = 1'b1; e.code = 2'b10;
            e.stall_cyc = int'(T) + 1;
        end
        return e;
    endfunction

    // Issue one access and play memory with an ack after d wait cycles (d >= T never acks)
    task automatic run_access(input bit w, input logic [1:0] sz, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int d, input logic [31:0] rw);
        int k = 0;
        bit seen = 1'b0;
        exp_q.push_back(model(w, sz, uns, a, wd, d, rw));
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                req_valid = 1'b0;
                mem_ack = ($urandom_range(0, 1) == 0);
                mem_rdata = $urandom;
            end else if (mem_req) begin
                mem_ack = (k == d);
                mem_rdata = (k == d) ? rw : $urandom;
                k++;
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
        if (!seen) begin
            n_fail++;
            $display("FAIL access_timeout: no done within 40 cycles, addr %h", a);
            $fatal(1, "access never completed");
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            mem_ack = ($urandom_range(0, 3) == 0);
        end
    endtask

    // Monitor: bus fields while mem_req is up, results and stall length on done
    initial begin
        int stall_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
            end else begin
                if (stall) stall_cnt++;
                if (mem_req) begin
                    if (exp_q.size() == 0) begin
                        chk("mem_req_unexpected", 32'(mem_req), 32'h0);
                    end else begin
                        e = exp_q[0];
                        chk("mem_req_allowed", 32'(mem_req), 32'(e.bus));
                        chk("mem_we", 32'(mem_we), 32'(e.we));
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_be", 32'(mem_be), 32'(e.be));
                        chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", rdata, e.rdata);
                        chk("exc", 32'(exc), 32'(e.exc));
                        chk("exc_code", 32'(exc_code), 32'(e.code));
                        chk("stall_cycles", 32'(stall_cnt), 32'(e.stall_cyc));
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_exc", 32'(exc), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        reset = 1'b0;
        idle(2);

        run_access(1'b1, 2'd0, 1'b0, 32'h1003, 32'h000000AB, 1, 32'h0);
        run_access(1'b0, 2'd0, 1'b0, 32'h2002, 32'h0, 0, 32'h12F45678);
        run_access(1'b0, 2'd0, 1'b1, 32'h2002, 32'h0, 0, 32'h12F45678);
        run_access(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 0, 32'h80010000);
        run_access(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 0, 32'h80010000);
        run_access(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 0, 32'h80010000);
        run_access(1'b0, 2'd2, 1'b0, 32'h0006, 32'h0, 0, 32'h0);
        run_access(1'b0, 2'd3, 1'b0, 32'h0000, 32'h0, 0, 32'h0);
        run_access(1'b1, 2'd2, 1'b0, 32'h0040, 32'hCAFEF00D, int'(T) + 2, 32'h0);
        run_access(1'b0, 2'd2, 1'b0, 32'h0044, 32'h0, int'(T) - 1, 32'h5A5A1234);
        idle(3);

        for (int i = 0; i < 200; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_access(1'($urandom), sz, 1'($urandom), $urandom, $urandom,
                       int'($urandom_range(0, T + 1)), $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Reset in the second BUSY cycle of a load aborts it without completion
        exp_q.push_back(model(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 0, 32'h0));
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h3000; req_wdata = 32'h0; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(mem_req), 32'h1);
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_mem_req", 32'(mem_req), 32'h0);
        chk("abort_stall", 32'(stall), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        void'(exp_q.pop_front());
        reset = 1'b0; mem_ack = 1'b1;
        @(posedge clk); #1;
        chk("stray_ack_done", 32'(done), 32'h0);
        chk("stray_ack_req", 32'(mem_req), 32'h0);
        mem_ack = 1'b0;
        run_access(1'b1, 2'd2, 1'b0, 32'h3004, 32'h01234567, 2, 32'h0);
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
